// File: rtl/rob_multi_commit_if.sv
// Bundle of allocate, writeback, commit, redirect and occupancy signals for rob_multi_commit.
// The master drives allocation/CDB/trap-vector inputs; the ROB is the slave.
interface rob_multi_commit_if #(
  parameter int ENTRIES = 32,
  parameter int W       = 2,
  parameter int C       = 2,
  parameter int XLEN    = 32,
  parameter int TAG_W   = $clog2(ENTRIES)
);
  logic [W-1:0]                 alloc_valid;
  logic                         alloc_ready;
  logic [W-1:0][XLEN-1:0]       alloc_pc;
  logic [W-1:0][4:0]            alloc_rd;
  logic [W-1:0]                 alloc_has_rd;
  logic [W-1:0][1:0]            alloc_kind;
  logic [W-1:0][TAG_W-1:0]      alloc_tags;

  logic [C-1:0]                 cdb_valid;
  logic [C-1:0][TAG_W-1:0]      cdb_tag;
  logic [C-1:0][XLEN-1:0]       cdb_result;
  logic [C-1:0]                 cdb_exc;
  logic [C-1:0][3:0]            cdb_cause;
  logic [XLEN-1:0]              mtvec;

  logic [W-1:0]                 commit_valid;
  logic [W-1:0]                 commit_we;
  logic [W-1:0]                 commit_store;
  logic [W-1:0][4:0]            commit_rd;
  logic [W-1:0][XLEN-1:0]       commit_data;
  logic [W-1:0][TAG_W-1:0]      commit_tag;

  logic                         flush;
  logic [XLEN-1:0]              flush_pc;
  logic                         exc_valid;
  logic [3:0]                   exc_cause;
  logic [XLEN-1:0]              exc_pc;

  logic [TAG_W-1:0]             head;
  logic [TAG_W-1:0]             tail;
  logic [TAG_W:0]               count;
  logic                         full;
  logic                         empty;

  modport master (
    output alloc_valid, alloc_pc, alloc_rd, alloc_has_rd, alloc_kind,
    output cdb_valid, cdb_tag, cdb_result, cdb_exc, cdb_cause, mtvec,
    input  alloc_ready, alloc_tags,
    input  commit_valid, commit_we, commit_store, commit_rd, commit_data, commit_tag,
    input  flush, flush_pc, exc_valid, exc_cause, exc_pc,
    input  head, tail, count, full, empty
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_rd, alloc_has_rd, alloc_kind,
    input  cdb_valid, cdb_tag, cdb_result, cdb_exc, cdb_cause, mtvec,
    output alloc_ready, alloc_tags,
    output commit_valid, commit_we, commit_store, commit_rd, commit_data, commit_tag,
    output flush, flush_pc, exc_valid, exc_cause, exc_pc,
    output head, tail, count, full, empty
  );
endinterface

// File: rtl/rob_multi_commit.sv
// W-wide in-order-retire reorder buffer with C CDB ports, precise flush and trap reporting.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module rob_multi_commit #(
  parameter int ENTRIES = 32,
  parameter int W       = 2,
  parameter int C       = 2,
  parameter int XLEN    = 32,
  parameter int TAG_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  rob_multi_commit_if.slave rob
);

  typedef enum logic [1:0] {
    K_ALU    = 2'b00,
    K_STORE  = 2'b01,
    K_BRANCH = 2'b10,
    K_JUMP   = 2'b11
  } kind_t;

  logic [TAG_W:0]   r_head_x;
  logic [TAG_W:0]   r_tail_x;
  logic             r_valid  [ENTRIES];
  logic             r_ready  [ENTRIES];
  logic             r_exc    [ENTRIES];
  logic [3:0]       r_cause  [ENTRIES];
  kind_t            r_kind   [ENTRIES];
  logic [XLEN-1:0]  r_pc     [ENTRIES];
  logic [4:0]       r_rd     [ENTRIES];
  logic             r_has_rd [ENTRIES];
  logic [XLEN-1:0]  r_result [ENTRIES];

  logic [TAG_W:0]   w_count;
  logic [TAG_W:0]   w_free;
  logic [TAG_W-1:0] w_head;
  logic [TAG_W-1:0] w_tail;
  logic [TAG_W-1:0] w_idx;
  logic [TAG_W:0]   w_n_commit;
  logic [TAG_W:0]   w_n_alloc;
  logic             w_stop;
  logic             w_flush;
  logic             w_alloc_fire;

  assign w_count   = r_tail_x - r_head_x;
  assign w_head    = r_head_x[TAG_W-1:0];
  assign w_tail    = r_tail_x[TAG_W-1:0];
  assign rob.head  = w_head;
  assign rob.tail  = w_tail;
  assign rob.count = w_count;
  assign rob.empty = (w_count == '0);
  assign rob.full  = (w_count == (TAG_W+1)'(ENTRIES));
  assign rob.flush = w_flush;

  // Scan the head window oldest-first; a not-ready entry or the first flushing slot ends the scan.
  always_comb begin
    rob.commit_valid = '0;
    rob.commit_we    = '0;
    rob.commit_store = '0;
    rob.commit_rd    = '0;
    rob.commit_data  = '0;
    rob.commit_tag   = '0;
    rob.flush_pc     = '0;
    rob.exc_valid    = 1'b0;
    rob.exc_cause    = '0;
    rob.exc_pc       = '0;
    w_flush          = 1'b0;
    w_stop           = 1'b0;
    w_n_commit       = '0;
    w_idx            = '0;
    for (int unsigned k = 0; k < W; k++) begin
      w_idx = w_head + TAG_W'(k);
      if (!w_stop) begin
        if (((TAG_W+1)'(k) < w_count) && r_valid[w_idx] && r_ready[w_idx]) begin
          if (r_exc[w_idx]) begin
            w_flush       = 1'b1;
            w_stop        = 1'b1;
            rob.flush_pc  = rob.mtvec;
            rob.exc_valid = 1'b1;
            rob.exc_cause = r_cause[w_idx];
            rob.exc_pc    = r_pc[w_idx];
          end else if (r_kind[w_idx] == K_BRANCH && r_result[w_idx][0]) begin
            w_flush      = 1'b1;
            w_stop       = 1'b1;
            rob.flush_pc = {r_result[w_idx][XLEN-1:1], 1'b0};
          end else begin
            rob.commit_valid[k] = 1'b1;
            rob.commit_rd[k]    = r_rd[w_idx];
            rob.commit_tag[k]   = w_idx;
            w_n_commit          = w_n_commit + (TAG_W+1)'(1);
            case (r_kind[w_idx])
              K_ALU: begin
                rob.commit_we[k]   = r_has_rd[w_idx];
                rob.commit_data[k] = r_result[w_idx];
              end
              K_STORE: rob.commit_store[k] = 1'b1;
              K_BRANCH: ;
              K_JUMP: begin
                rob.commit_we[k]   = r_has_rd[w_idx];
                rob.commit_data[k] = r_pc[w_idx] + XLEN'(4);
                w_flush            = 1'b1;
                w_stop             = 1'b1;
                rob.flush_pc       = {r_result[w_idx][XLEN-1:1], 1'b0};
              end
            endcase
          end
        end else begin
          w_stop = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_free          = (TAG_W+1)'(ENTRIES) - w_count;
    rob.alloc_ready = !w_flush && (w_free >= (TAG_W+1)'(W));
    w_alloc_fire    = rob.alloc_ready && rob.alloc_valid[0];
    w_n_alloc       = '0;
    rob.alloc_tags  = '0;
    for (int unsigned i = 0; i < W; i++) begin
      rob.alloc_tags[i] = w_tail + TAG_W'(i);
      if (rob.alloc_valid[i]) w_n_alloc = w_n_alloc + (TAG_W+1)'(1);
    end
  end

  // Statement order matters: CDB capture, then retire invalidation, then allocation.
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_head_x <= '0;
      r_tail_x <= '0;
      for (int unsigned e = 0; e < ENTRIES; e++) r_valid[e] <= 1'b0;
    end else begin
      for (int unsigned q = 0; q < C; q++) begin
        if (rob.cdb_valid[C-1-q] && r_valid[rob.cdb_tag[C-1-q]]) begin
          r_ready[rob.cdb_tag[C-1-q]]  <= 1'b1;
          r_result[rob.cdb_tag[C-1-q]] <= rob.cdb_result[C-1-q];
          r_exc[rob.cdb_tag[C-1-q]]    <= rob.cdb_exc[C-1-q];
          r_cause[rob.cdb_tag[C-1-q]]  <= rob.cdb_cause[C-1-q];
        end
      end
      for (int unsigned k = 0; k < W; k++) begin
        if (rob.commit_valid[k]) r_valid[w_head + TAG_W'(k)] <= 1'b0;
      end
      if (w_alloc_fire) begin
        for (int unsigned i = 0; i < W; i++) begin
          if (rob.alloc_valid[i]) begin
            r_valid[w_tail + TAG_W'(i)]  <= 1'b1;
            r_ready[w_tail + TAG_W'(i)]  <= (rob.alloc_kind[i] == K_STORE);
            r_exc[w_tail + TAG_W'(i)]    <= 1'b0;
            r_cause[w_tail + TAG_W'(i)]  <= '0;
            r_kind[w_tail + TAG_W'(i)]   <= kind_t'(rob.alloc_kind[i]);
            r_pc[w_tail + TAG_W'(i)]     <= rob.alloc_pc[i];
            r_rd[w_tail + TAG_W'(i)]     <= rob.alloc_rd[i];
            r_has_rd[w_tail + TAG_W'(i)] <= rob.alloc_has_rd[i];
          end
        end
        r_tail_x <= r_tail_x + w_n_alloc;
      end
      r_head_x <= r_head_x + w_n_commit;
    end
  end

endmodule

// File: doc/rob_multi_commit.md
# rob_multi_commit

Parametrised reorder buffer for the out-of-order backend, generalising the 2-wide ROB to W-wide allocate/commit, C CDB ports and power-of-two depth. It allocates tags in program order from Rename/Dispatch in a single cycle, captures results from the CDBs, and retires up to W instructions per cycle in order. It produces precise flush/redirect, including a real exception trap target and cause, and reports occupancy (count/full/empty).

## Interface
- ENTRIES, 32, ROB depth; power of two, at least 4.
- W, 2, allocate and commit lanes, 1..4; ENTRIES must be a multiple of W.
- C, 2, CDB ports.
- XLEN, 32, data/PC width.
- TAG_W, $clog2(ENTRIES), tag width (derived).
- clk  in  1  clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- alloc_valid  in  W  lane requests; contiguous from lane 0.
- alloc_ready  out  1  whole group accepted when high.
- alloc_pc / alloc_rd / alloc_has_rd  in  W×XLEN / W×5 / W  per-lane instruction info.
- alloc_kind  in  W×2  00 ALU, 01 STORE, 10 BRANCH, 11 JUMP.
- alloc_tags  out  W×TAG_W  tail+i mod ENTRIES for lane i; always driven.
- cdb_valid / cdb_tag / cdb_result  in  C / C×TAG_W / C×XLEN  writeback.
- cdb_exc / cdb_cause  in  C / C×4  exception flag and cause.
- mtvec  in  XLEN  trap target.
- commit_valid / commit_we / commit_store  out  W each  per-slot retire, PRF write enable, store release.
- commit_rd / commit_data / commit_tag  out  W×5 / W×XLEN / W×TAG_W.
- flush / flush_pc  out  1 / XLEN  combinational redirect.
- exc_valid / exc_cause / exc_pc  out  1 / 4 / XLEN  trap report.
- head / tail  out  TAG_W each.
- count  out  TAG_W+1.
- full / empty  out  1 each.

## Operation
- **Pointers:** head_x and tail_x are TAG_W+1 bits, with the MSB acting as a wrap bit.
  - count = tail_x − head_x; empty = (count==0); full = (count==ENTRIES).
  - head and tail outputs are the low TAG_W bits.
- **alloc_ready** = !flush && (ENTRIES − count ≥ W). Free space comes from registered count only; a same-cycle commit never frees space for a same-cycle allocate.
- **Allocation:** happens on alloc_ready && alloc_valid[0]. For each valid lane i, entry tail+i is written with valid=1, ready=(kind==STORE), exc=0, and the lane info. Tail advances by popcount(alloc_valid).
- **CDB capture:** on cdb_valid[p], if the entry at cdb_tag is valid, write ready=1, result, exc and cause. Writes to invalid entries are ignored. If two ports target one tag, the lowest port wins.
- **Commit slot k (0..W−1):** examines entry head+k, only when k < count. The slot fires if the entry is valid and ready, every slot j<k committed, and no slot j<k flushed.
  - ALU: commit_we = has_rd; data = result.
  - STORE: commit_store = 1; we = 0.
  - BRANCH, result[0]==0: commits with we = 0.
  - BRANCH, result[0]==1 (mispredict): no commit; flush with flush_pc = {result[XLEN−1:1],0}.
  - JUMP: commits with data = pc+4, we = has_rd, and flushes with flush_pc = {result[XLEN−1:1],0}.
  - exc=1 (any kind): no commit; flush with flush_pc = mtvec, exc_valid = 1, exc_cause = cause, exc_pc = pc.
- **Flush scope:** only the oldest flushing slot acts. No slot after it is examined.
- **Pointer update:** head advances by the number of committed slots and committed entries are invalidated.
- **Flush effect:** on a flush cycle, commits of older slots still retire. At the edge, all entries are invalidated, head_x = tail_x = 0, and allocation that cycle is dropped.
- **Unused outputs:** unused commit lanes drive zero. The flush, exc and commit outputs are zero when inactive.

## Timing
- Reset (synchronous, at rising edge with rst=1) values:
  - head, tail, count, and every commit_*, flush*, exc* output = 0.
  - empty = 1, full = 0.
  - alloc_ready = 1.
  - alloc_tags = 0..W−1.
  - All entries invalid.
- Latency:
  - Allocation at edge t: entry is visible to commit from t+1. A STORE at head can commit in cycle t+1.
  - CDB at edge t: entry can commit from cycle t+1.
  - Flush: asserted in the same cycle the head-window entry is ready; state is empty from the next cycle.
- Wrap-around: pointer arithmetic is modulo 2·ENTRIES. Tags wrap modulo ENTRIES. Full and empty are distinguished by the wrap bit.
- Simultaneous events:
  - Allocate and commit in the same cycle: both apply; count' = count + allocated − committed.
  - CDB write to an entry committing in the same cycle cannot occur (the entry is already ready); if it does, it is ignored.
- Reset mid-operation: it overrides flush, allocate, CDB capture and commit in that cycle.

## Test plan
- **Reset:** assert rst for 2 cycles with random inputs → empty=1, count=0, alloc_tags={0,1}, commit_valid=0, flush=0.
- **Fill and wrap (ENTRIES=8, W=2):** 4 allocations → full=1, alloc_ready=0. CDB all 8 tags → commits of tags 0,1 / 2,3 / 4,5 / 6,7 in consecutive cycles. Then reallocate → tail wraps to 0, and count matches the wrap bit.
- **Out-of-order writeback:** allocate ALU tags 0,1,2. CDB writes tag2, then 1, then 0 on successive cycles → no commit until tag0 is ready. Then tags 0 and 1 commit in the same cycle, and tag2 commits the next cycle.
- **Mispredict in slot 1:** tag0 ALU ready (rd=5, result=7); tag1 BRANCH result=0x101 → slot0 commits (rd 5, data 7, we=1). Slot1 does not commit; flush=1, flush_pc=0x100. Next cycle empty=1.
- **Exception:** head ALU with pc=0x40 receives cdb_exc=1, cause=2; mtvec=0x80 → commit_valid=0, exc_valid=1, exc_cause=2, exc_pc=0x40, flush_pc=0x80.
- **JUMP plus store:** tag0 STORE, tag1 JUMP (pc=0x20, rd=1, result=0x200) → commit_store[0]=1. Slot1 commits data=0x24 and we=1, with flush_pc=0x200 in the same cycle.
